// File: rtl/z80_bus_pkg.sv
// Shared definitions for the tv80s strobe-bus bridge and future bus monitors.
package z80_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } bridge_state_t;

    typedef enum logic [1:0] {
        CYC_NONE,
        CYC_MEM,
        CYC_IO
    } cycle_t;

    localparam logic [7:0] IDLE_DATA_DEF = 8'hFF;

    // Refresh and interrupt-acknowledge cycles decode as CYC_NONE.
    function automatic cycle_t decode_cycle(
        input logic m1_n,
        input logic mreq_n,
        input logic iorq_n,
        input logic rd_n,
        input logic wr_n,
        input logic rfsh_n
    );
        logic xfer;
        xfer = !rd_n || !wr_n;
        if (!mreq_n && rfsh_n && xfer)
            return CYC_MEM;
        if (!iorq_n && m1_n && xfer)
            return CYC_IO;
        return CYC_NONE;
    endfunction

endpackage

// File: rtl/z80_bus_bridge.sv
// Converts tv80s strobe cycles into req/ack backend transactions, stalling
// the CPU with wait_n until the backend acknowledges or the request times out.
module z80_bus_bridge
    import z80_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [7:0]  IDLE_DATA = IDLE_DATA_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    input  logic [15:0] A,
    input  logic [7:0]  dout,
    output logic [7:0]  di,
    output logic        wait_n,
    output logic        req,
    output logic        we,
    output logic        is_io,
    output logic [15:0] addr,
    output logic [7:0]  wdata,
    input  logic        ack,
    input  logic [7:0]  rdata,
    output logic        err
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    bridge_state_t state;
    cycle_t        cyc;
    logic          start;
    logic [CW-1:0] cnt;

    always_comb begin
        cyc   = decode_cycle(m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n);
        start = (state == IDLE) && (cyc != CYC_NONE);
    end

    // The stall must appear in the strobe cycle itself, so wait_n is not registered.
    assign wait_n = !((state == REQ) || start);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            req   <= 1'b0;
            we    <= 1'b0;
            is_io <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            di    <= IDLE_DATA;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= REQ;
                        req   <= 1'b1;
                        we    <= !wr_n;
                        is_io <= (cyc == CYC_IO);
                        addr  <= (cyc == CYC_IO) ? {8'h00, A[7:0]} : A;
                        wdata <= dout;
                        cnt   <= '0;
                    end else if (!m1_n && !iorq_n) begin
                        di <= IDLE_DATA;
                    end
                end
                REQ: begin
                    // ack takes priority over an expiry in the same cycle.
                    if (ack) begin
                        state <= DONE;
                        req   <= 1'b0;
                        if (!we)
                            di <= rdata;
                    end else if (TIMEOUT != 0 && cnt == TMAX) begin
                        state <= DONE;
                        req   <= 1'b0;
                        di    <= IDLE_DATA;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if ((mreq_n && iorq_n) || (rd_n && wr_n))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Self-checking bench for z80_bus_bridge: emulates CPU strobe cycles and a
// backend with random ack latency, compared against a transaction-level model.
module tb_z80_bus_bridge;

    localparam int unsigned TO    = 4;
    localparam int unsigned NEVER = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic [15:0] A;
    logic [7:0]  dout;
    logic [7:0]  di;
    logic        wait_n, req, we, is_io;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ack;
    logic [7:0]  rdata;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state
    logic [7:0] di_m;
    logic       err_m;

    z80_bus_bridge #(.TIMEOUT(TO), .IDLE_DATA(8'hFF)) dut (
        .clk(clk), .reset(reset), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .A(A), .dout(dout), .di(di),
        .wait_n(wait_n), .req(req), .we(we), .is_io(is_io), .addr(addr),
        .wdata(wdata), .ack(ack), .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    task automatic bus_idle();
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
        rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One CPU bus cycle; backend acks k cycles into REQ (k > TO means never).
    task automatic run_txn(input bit io, input bit wr, input logic [15:0] a,
                           input logic [7:0] d, input logic [7:0] rd,
                           input int unsigned k, input string name);
        int unsigned stall, reqs, exp_req;
        logic [15:0] exp_addr;
        bit finished;
        stall = 0; reqs = 0; finished = 0;
        exp_addr = io ? {8'h00, a[7:0]} : a;
        exp_req  = ((k <= TO) ? k : TO) + 1;
        next_cycle();
        A = a; dout = d; ack = 1'b0;
        if (io) begin iorq_n = 1'b0; m1_n = 1'b1; end
        else    begin mreq_n = 1'b0; m1_n = 1'b1; end
        if (wr) wr_n = 1'b0; else rd_n = 1'b0;
        for (int c = 0; c < int'(TO) + 4; c++) begin
            ack   = (c >= 1) && (c - 1 == int'(k));
            rdata = ack ? rd : 8'($urandom);
            @(negedge clk);
            if (!wait_n) stall++;
            if (req) begin
                reqs++;
                checks++;
                if (addr !== exp_addr || we !== wr || is_io !== io || (wr && wdata !== d)) begin
                    errors++;
                    $display("FAIL %s req_fields: addr=%h we=%b io=%b wdata=%h, want addr=%h we=%b io=%b wdata=%h",
                             name, addr, we, is_io, wdata, exp_addr, wr, io, d);
                end
            end
            if (c > 0 && wait_n) begin
                finished = 1;
                break;
            end
            next_cycle();
        end
        ack = 1'b0;
        if (k <= TO) begin
            if (!wr) di_m = rd;
        end else begin
            di_m  = 8'hFF;
            err_m = 1'b1;
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s wait_release: wait_n still low after %0d cycles", name, TO + 4);
        end
        checks++;
        if (stall !== exp_req + 1 || reqs !== exp_req) begin
            errors++;
            $display("FAIL %s stall: stall=%0d req_cycles=%0d, want stall=%0d req_cycles=%0d",
                     name, stall, reqs, exp_req + 1, exp_req);
        end
        checks++;
        if (di !== di_m || err !== err_m || req !== 1'b0) begin
            errors++;
            $display("FAIL %s result: di=%h err=%b req=%b, want di=%h err=%b req=0",
                     name, di, err, req, di_m, err_m);
        end
        // Strobes held past completion must not trigger a second request.
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (req !== 1'b0 || wait_n !== 1'b1) begin
                errors++;
                $display("FAIL %s no_rerequest: req=%b wait_n=%b, want req=0 wait_n=1", name, req, wait_n);
            end
        end
        next_cycle();
        bus_idle();
    endtask

    task automatic test_reset();
        bus_idle();
        A = '0; dout = '0; ack = 1'b0; rdata = '0;
        reset = 1'b1;
        repeat (2) next_cycle();
        reset = 1'b0;
        di_m = 8'hFF; err_m = 1'b0;
        @(negedge clk);
        checks++;
        if (req !== 1'b0 || wait_n !== 1'b1 || di !== 8'hFF || err !== 1'b0 ||
            addr !== 16'h0 || we !== 1'b0 || is_io !== 1'b0 || wdata !== 8'h0) begin
            errors++;
            $display("FAIL reset_values: req=%b wait_n=%b di=%h err=%b addr=%h we=%b io=%b wdata=%h",
                     req, wait_n, di, err, addr, we, is_io, wdata);
        end
    endtask

    task automatic test_mem_read();
        run_txn(1'b0, 1'b0, 16'h0000, 8'h00, 8'h7B, 3, "mem_read");
    endtask

    task automatic test_mem_write();
        run_txn(1'b0, 1'b1, 16'hA169, 8'h5A, 8'h99, 0, "mem_write");
    endtask

    task automatic test_io_read();
        run_txn(1'b1, 1'b0, 16'h1234, 8'h00, 8'hC3, $urandom_range(0, 3), "io_read");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_txn(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom),
                    8'($urandom), $urandom_range(0, 3), "random");
    endtask

    task automatic test_refresh();
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            m1_n = 1'b1; mreq_n = 1'b0; rfsh_n = 1'b0;
            rd_n = 1'($urandom); wr_n = 1'b1; A = 16'($urandom);
            @(negedge clk);
            checks++;
            if (req !== 1'b0 || wait_n !== 1'b1) begin
                errors++;
                $display("FAIL refresh: req=%b wait_n=%b, want req=0 wait_n=1", req, wait_n);
            end
        end
        next_cycle();
        bus_idle();
    endtask

    task automatic test_intack();
        run_txn(1'b0, 1'b0, 16'h0042, 8'h00, 8'h5A, 1, "pre_intack");
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            m1_n = 1'b0; iorq_n = 1'b0; mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
            @(negedge clk);
            checks++;
            if (req !== 1'b0 || wait_n !== 1'b1) begin
                errors++;
                $display("FAIL intack_no_req: req=%b wait_n=%b, want req=0 wait_n=1", req, wait_n);
            end
        end
        di_m = 8'hFF;
        checks++;
        if (di !== di_m) begin
            errors++;
            $display("FAIL intack_di: di=%h, want %h", di, di_m);
        end
        next_cycle();
        bus_idle();
    endtask

    task automatic test_stray_ack();
        run_txn(1'b0, 1'b0, 16'h1000, 8'h00, 8'h3C, 2, "pre_stray");
        next_cycle();
        ack = 1'b1; rdata = 8'hA5;
        next_cycle();
        ack = 1'b0;
        @(negedge clk);
        checks++;
        if (req !== 1'b0 || wait_n !== 1'b1 || di !== di_m) begin
            errors++;
            $display("FAIL stray_ack: req=%b wait_n=%b di=%h, want req=0 wait_n=1 di=%h", req, wait_n, di, di_m);
        end
    endtask

    task automatic test_ack_at_expiry();
        run_txn(1'b0, 1'b0, 16'h2222, 8'h00, 8'h81, TO, "ack_at_expiry");
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 1'b0, 16'h3333, 8'h00, 8'h00, NEVER, "timeout");
        run_txn(1'b1, 1'b1, 16'h00F0, 8'h77, 8'h00, 1, "after_timeout");
    endtask

    task automatic test_reset_mid_req();
        next_cycle();
        A = 16'h4567; m1_n = 1'b1; mreq_n = 1'b0; rd_n = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        checks++;
        if (req !== 1'b1) begin
            errors++;
            $display("FAIL mid_req_active: req=%b, want 1", req);
        end
        next_cycle();
        reset = 1'b1;
        bus_idle();
        next_cycle();
        reset = 1'b0;
        di_m = 8'hFF; err_m = 1'b0;
        @(negedge clk);
        checks++;
        if (req !== 1'b0 || wait_n !== 1'b1 || err !== 1'b0 || di !== di_m) begin
            errors++;
            $display("FAIL reset_mid_req: req=%b wait_n=%b err=%b di=%h, want 0 1 0 %h", req, wait_n, err, di, di_m);
        end
        next_cycle();
        ack = 1'b1; rdata = 8'h12;
        next_cycle();
        ack = 1'b0;
        @(negedge clk);
        checks++;
        if (req !== 1'b0 || wait_n !== 1'b1 || di !== di_m) begin
            errors++;
            $display("FAIL late_ack: req=%b wait_n=%b di=%h, want req=0 wait_n=1 di=%h", req, wait_n, di, di_m);
        end
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_mem_write();
        test_io_read();
        test_random();
        test_refresh();
        test_intack();
        test_stray_ack();
        test_ack_at_expiry();
        test_timeout();
        test_reset_mid_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
